// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle 16-bit CPU: opcode values, FSM
// state encoding, instruction field positions and the HALT instruction word.
package cpu_pkg;

  // Opcodes (instruction bits [15:12]); 4'hC..4'hE are undefined.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Instruction field LSB positions.
  localparam int OP_LSB    = 12;  // 4 bits
  localparam int DST_LSB   = 9;   // 3 bits
  localparam int SRC1_LSB  = 6;   // 3 bits
  localparam int SRC2_LSB  = 3;   // 3 bits
  localparam int SHAMT_LSB = 0;   // 3 bits
  localparam int ICONST_W  = 6;   // signed, bits [5:0]
  localparam int JCONST_W  = 9;   // unsigned, bits [8:0]

  // Returned by fetches beyond the end of instruction memory.
  localparam logic [15:0] HALT_WORD = 16'hF000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_t;

  function automatic logic is_undef_op(input logic [3:0] op);
    return (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for cpu_mc_core.
// Ports: op (opcode), a/b (operands), shamt (shift amount), imm (sign-extended
// immediate), result. ADDI/LW/SW all produce a+imm (value or effective address).
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        shamt,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:                result = a + b;
      OP_SUB:                result = a - b;
      OP_AND:                result = a & b;
      OP_OR:                 result = a | b;
      OP_SLL:                result = a << shamt;
      OP_SRL:                result = a >> shamt;
      OP_ADDI, OP_LW, OP_SW: result = a + imm;
      default:               result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_mc_core.sv
// Multi-cycle 16-bit CPU core: loadable instruction memory, 8-entry register
// file (r0 hard zero), data memory and a FETCH/DECODE/EXEC/MEM/WB sequencer.
// Ports: clk, reset (sync, active-high), start (launch from pc=0),
// imem_we/imem_addr/imem_wdata (program load, only while not busy),
// dbg_raddr/dbg_rdata (combinational register peek), pc, busy, halted,
// retire (one pulse per completed instruction), illegal (sticky bad opcode).
module cpu_mc_core
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NREG       = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 8,
  parameter int PC_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              imem_we,
  input  logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_wdata,
  input  logic [2:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted,
  output logic              retire,
  output logic              illegal
);

  localparam int IA = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DA = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [15:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] rf   [NREG];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  state_t            state_reg, state_next;
  logic [PC_W-1:0]   pc_reg;
  logic [15:0]       ir_reg;
  logic [DATA_W-1:0] a_reg, b_reg, alu_reg, mdr_reg;
  logic              retire_reg, retire_next;
  logic              illegal_reg;

  // Decoded fields of the current instruction.
  logic [3:0]        op;
  logic [2:0]        dst, src1, src2, shamt;
  logic [DATA_W-1:0] imm_data;
  logic [PC_W-1:0]   br_off, jmp_target;
  logic [DATA_W-1:0] alu_result;
  logic [15:0]       fetch_word;
  logic              fetch_in_range;

  assign op         = ir_reg[OP_LSB +: 4];
  assign dst        = ir_reg[DST_LSB +: 3];
  assign src1       = ir_reg[SRC1_LSB +: 3];
  assign src2       = ir_reg[SRC2_LSB +: 3];
  assign shamt      = ir_reg[SHAMT_LSB +: 3];
  assign imm_data   = DATA_W'($signed(ir_reg[ICONST_W-1:0]));
  assign br_off     = PC_W'($signed(ir_reg[ICONST_W-1:0]));
  assign jmp_target = PC_W'(ir_reg[JCONST_W-1:0]);

  // Fetches past the loaded program run into an implicit HALT.
  assign fetch_in_range = 32'(pc_reg) < IMEM_DEPTH;
  assign fetch_word     = fetch_in_range ? imem[pc_reg[IA-1:0]] : HALT_WORD;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (a_reg),
    .b      (b_reg),
    .shamt  (shamt),
    .imm    (imm_data),
    .result (alu_result)
  );

  assign busy      = (state_reg != S_IDLE) && (state_reg != S_HALTED);
  assign halted    = (state_reg == S_HALTED);
  assign retire    = retire_reg;
  assign illegal   = illegal_reg;
  assign pc        = pc_reg;
  assign dbg_rdata = (dbg_raddr == 3'd0) ? '0 : rf[dbg_raddr];

  // Program load port; instruction memory is not cleared by reset.
  always_ff @(posedge clk) begin
    if (imem_we && !busy && (32'(imem_addr) < IMEM_DEPTH))
      imem[imem_addr[IA-1:0]] <= imem_wdata;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_HALTED: if (start) state_next = S_FETCH;
      S_FETCH:          state_next = S_DECODE;
      S_DECODE:         state_next = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_SLL, OP_SRL, OP_ADDI: state_next = S_WB;
          OP_LW, OP_SW:            state_next = S_MEM;
          OP_HALT:                 state_next = S_HALTED;
          default:                 state_next = S_FETCH;
        endcase
      end
      S_MEM:   state_next = (op == OP_LW) ? S_WB : S_FETCH;
      S_WB:    state_next = S_FETCH;
      default: state_next = S_IDLE;
    endcase
    // An instruction completes whenever an execution state hands back to
    // FETCH or HALTED; the pulse is registered so it shows a cycle later.
    retire_next = ((state_reg == S_EXEC) || (state_reg == S_MEM) || (state_reg == S_WB))
                  && ((state_next == S_FETCH) || (state_next == S_HALTED));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      pc_reg      <= '0;
      ir_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      alu_reg     <= '0;
      mdr_reg     <= '0;
      retire_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      for (int i = 0; i < NREG; i++)       rf[i]   <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
    end else begin
      state_reg  <= state_next;
      retire_reg <= retire_next;
      case (state_reg)
        S_IDLE, S_HALTED: begin
          if (start) begin
            pc_reg      <= '0;
            illegal_reg <= 1'b0;
          end
        end
        S_FETCH: begin
          ir_reg <= fetch_word;
          pc_reg <= pc_reg + PC_W'(1);
        end
        S_DECODE: begin
          a_reg <= rf[src1];
          // SW stores rf[dst]; BEQ compares rf[dst] against rf[src1].
          b_reg <= ((op == OP_SW) || (op == OP_BEQ)) ? rf[dst] : rf[src2];
        end
        S_EXEC: begin
          alu_reg <= alu_result;
          if ((op == OP_BEQ) && (a_reg == b_reg)) pc_reg <= pc_reg + br_off;
          if (op == OP_JMP)                       pc_reg <= jmp_target;
          if (is_undef_op(op))                    illegal_reg <= 1'b1;
        end
        S_MEM: begin
          if (op == OP_SW) dmem[alu_reg[DA-1:0]] <= b_reg;
          else             mdr_reg <= dmem[alu_reg[DA-1:0]];
        end
        S_WB: begin
          if (dst != 3'd0) rf[dst] <= (op == OP_LW) ? mdr_reg : alu_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mc_core.sv
// Directed testbench for cpu_mc_core: small hand-assembled programs with
// hand-computed register values, retire counts, cycle counts and pc values.
module tb_cpu_mc_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_addr = '0;
  logic [15:0] imem_wdata = '0;
  logic [2:0]  dbg_raddr = '0;
  logic [15:0] dbg_rdata;
  logic [7:0]  pc;
  logic        busy, halted, retire, illegal;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] prog [16];

  always #5 clk = ~clk;

  cpu_mc_core dut (
    .clk(clk), .reset(reset), .start(start), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata), .pc(pc), .busy(busy), .halted(halted),
    .retire(retire), .illegal(illegal)
  );

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] d,
                                        input logic [2:0] s1, input logic [2:0] s2);
    return {op, d, s1, s2, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] d,
                                        input logic [2:0] s1, input logic [5:0] k);
    return {op, d, s1, k};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      imem_we = 1'b1; imem_addr = 8'(i); imem_wdata = prog[i];
      @(posedge clk); #1;
    end
    imem_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] r, output logic [15:0] v);
    dbg_raddr = r;
    #1;
    v = dbg_rdata;
  endtask

  // Pulses start, then counts busy cycles and retire pulses until HALTED.
  // With poke set, tries to overwrite imem[2] during the first busy cycle.
  task automatic run_program(input int budget, input bit poke,
                             output int cycles, output int retires, output bit timeout);
    cycles = 0; retires = 0; timeout = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (poke && i == 0) begin
        imem_we = 1'b1; imem_addr = 8'd2; imem_wdata = 16'h7C09;
      end else begin
        imem_we = 1'b0;
      end
      if (retire) retires++;
      if (halted) begin timeout = 1'b0; break; end
      if (busy) cycles++;
      @(posedge clk); #1;
    end
    imem_we = 1'b0;
  endtask

  task automatic load_prog1();
    for (int i = 0; i < 16; i++) prog[i] = 16'hF000;
    prog[0] = enc_i(4'h7, 3'd1, 3'd0, 6'd5);        // ADDI r1,r0,5
    prog[1] = enc_i(4'h7, 3'd2, 3'd0, 6'h3D);       // ADDI r2,r0,-3
    prog[2] = enc_r(4'h1, 3'd3, 3'd1, 3'd2);        // ADD r3,r1,r2
    prog[3] = 16'hF000;                             // HALT
    load_prog();
  endtask

  task automatic test_reset();
    logic [15:0] v;
    do_reset();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %0b want 0", halted); end
    vectors++; if (retire !== 1'b0) begin miscompares++; $display("FAIL reset_retire got %0b want 0", retire); end
    vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal got %0b want 0", illegal); end
    vectors++; if (pc !== 8'd0) begin miscompares++; $display("FAIL reset_pc got %0h want 0", pc); end
    for (int r = 1; r < 8; r++) begin
      rd(3'(r), v);
      vectors++; if (v !== 16'd0) begin miscompares++; $display("FAIL reset_r%0d got %0h want 0", r, v); end
    end
    $display("test_reset done");
  endtask

  task automatic test_arith();
    int cyc, ret; bit to; logic [15:0] v;
    do_reset();
    load_prog1();
    run_program(100, 1'b0, cyc, ret, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL arith_timeout got %0b want 0", to); end
    rd(3'd3, v);
    vectors++; if (v !== 16'd2) begin miscompares++; $display("FAIL arith_r3 got %0h want 2", v); end
    rd(3'd2, v);
    vectors++; if (v !== 16'hFFFD) begin miscompares++; $display("FAIL arith_r2 got %0h want fffd", v); end
    vectors++; if (ret !== 4) begin miscompares++; $display("FAIL arith_retires got %0d want 4", ret); end
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL arith_halted got %0b want 1", halted); end
    vectors++; if (pc !== 8'd4) begin miscompares++; $display("FAIL arith_pc got %0h want 4", pc); end
    // 3 x 4-cycle ALU/ADDI + 3-cycle HALT
    vectors++; if (cyc !== 15) begin miscompares++; $display("FAIL arith_cycles got %0d want 15", cyc); end
    $display("test_arith cycles=%0d retires=%0d", cyc, ret);
  endtask

  task automatic test_mem();
    int cyc, ret; bit to; logic [15:0] v;
    do_reset();
    for (int i = 0; i < 16; i++) prog[i] = 16'hF000;
    prog[0] = enc_i(4'h7, 3'd1, 3'd0, 6'd5);        // ADDI r1,r0,5
    prog[1] = enc_i(4'h9, 3'd1, 3'd0, 6'd2);        // SW r1,[r0+2]
    prog[2] = enc_i(4'h8, 3'd4, 3'd0, 6'd10);       // LW r4,[r0+10] -> wraps to 2
    load_prog();
    run_program(100, 1'b0, cyc, ret, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL mem_timeout got %0b want 0", to); end
    rd(3'd4, v);
    vectors++; if (v !== 16'd5) begin miscompares++; $display("FAIL mem_r4 got %0h want 5", v); end
    // ADDI 4 + SW 4 + LW 5 + HALT 3
    vectors++; if (cyc !== 16) begin miscompares++; $display("FAIL mem_cycles got %0d want 16", cyc); end
    vectors++; if (ret !== 4) begin miscompares++; $display("FAIL mem_retires got %0d want 4", ret); end
    $display("test_mem cycles=%0d retires=%0d", cyc, ret);
  endtask

  task automatic test_branch_loop();
    int cyc, ret; bit to; logic [15:0] v;
    do_reset();
    for (int i = 0; i < 16; i++) prog[i] = 16'hF000;
    prog[0] = enc_i(4'h7, 3'd1, 3'd0, 6'd3);        // ADDI r1,r0,3
    prog[1] = enc_i(4'h7, 3'd1, 3'd1, 6'h3F);       // ADDI r1,r1,-1
    prog[2] = enc_i(4'hA, 3'd1, 3'd0, 6'd1);        // BEQ r1,r0,+1
    prog[3] = 16'hB001;                             // JMP 1
    prog[4] = 16'hF000;                             // HALT
    load_prog();
    run_program(200, 1'b0, cyc, ret, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL loop_timeout got %0b want 0", to); end
    rd(3'd1, v);
    vectors++; if (v !== 16'd0) begin miscompares++; $display("FAIL loop_r1 got %0h want 0", v); end
    // setup 1 + two full passes (3 each) + final ADDI,BEQ + HALT
    vectors++; if (ret !== 10) begin miscompares++; $display("FAIL loop_retires got %0d want 10", ret); end
    vectors++; if (pc !== 8'd5) begin miscompares++; $display("FAIL loop_pc got %0h want 5", pc); end
    // 4 ADDI x4 + 3 BEQ x3 + 2 JMP x3 + HALT 3
    vectors++; if (cyc !== 34) begin miscompares++; $display("FAIL loop_cycles got %0d want 34", cyc); end
    $display("test_branch_loop cycles=%0d retires=%0d", cyc, ret);
  endtask

  task automatic test_illegal();
    int cyc, ret; bit to; logic [15:0] v;
    do_reset();
    for (int i = 0; i < 16; i++) prog[i] = 16'hF000;
    prog[0] = enc_i(4'h7, 3'd1, 3'd0, 6'd1);        // ADDI r1,r0,1
    prog[1] = 16'hDFFF;                             // undefined, dst field r7
    prog[2] = enc_i(4'h7, 3'd2, 3'd0, 6'd2);        // ADDI r2,r0,2
    load_prog();
    run_program(100, 1'b0, cyc, ret, to);
    vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL illegal_set got %0b want 1", illegal); end
    rd(3'd2, v);
    vectors++; if (v !== 16'd2) begin miscompares++; $display("FAIL illegal_continue_r2 got %0h want 2", v); end
    rd(3'd7, v);
    vectors++; if (v !== 16'd0) begin miscompares++; $display("FAIL illegal_r7 got %0h want 0", v); end
    vectors++; if (ret !== 4) begin miscompares++; $display("FAIL illegal_retires got %0d want 4", ret); end
    // Restart from HALTED: flag clears immediately, pc back to 0.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL illegal_cleared got %0b want 0", illegal); end
    vectors++; if (pc !== 8'd0) begin miscompares++; $display("FAIL illegal_restart_pc got %0h want 0", pc); end
    for (int i = 0; i < 100 && !halted; i++) begin @(posedge clk); #1; end
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL illegal_rerun_halt got %0b want 1", halted); end
    $display("test_illegal retires=%0d", ret);
  endtask

  task automatic test_reset_mid_wb();
    int cyc, ret; bit to; logic [15:0] v;
    do_reset();
    load_prog1();
    start = 1'b1;
    @(posedge clk); #1;                             // busy cycle 1 (FETCH of ADDI r1)
    start = 1'b0;
    repeat (11) begin @(posedge clk); #1; end       // busy cycle 12 = WB of ADD r3
    rd(3'd1, v);
    vectors++; if (v !== 16'd5) begin miscompares++; $display("FAIL midwb_r1_before got %0h want 5", v); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rd(3'd3, v);
    vectors++; if (v !== 16'd0) begin miscompares++; $display("FAIL midwb_r3 got %0h want 0", v); end
    rd(3'd1, v);
    vectors++; if (v !== 16'd0) begin miscompares++; $display("FAIL midwb_r1 got %0h want 0", v); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midwb_busy got %0b want 0", busy); end
    run_program(100, 1'b0, cyc, ret, to);
    rd(3'd3, v);
    vectors++; if (v !== 16'd2) begin miscompares++; $display("FAIL midwb_rerun_r3 got %0h want 2", v); end
    vectors++; if (cyc !== 15) begin miscompares++; $display("FAIL midwb_rerun_cycles got %0d want 15", cyc); end
    $display("test_reset_mid_wb rerun cycles=%0d", cyc);
  endtask

  task automatic test_busy_write_overflow();
    int cyc, ret; bit to; logic [15:0] v;
    do_reset();
    for (int i = 0; i < 16; i++) prog[i] = 16'h0000;  // NOPs, no HALT
    prog[0] = enc_i(4'h7, 3'd0, 3'd0, 6'd7);        // ADDI r0,r0,7
    prog[1] = enc_i(4'h7, 3'd5, 3'd0, 6'd1);        // ADDI r5,r0,1
    load_prog();
    run_program(200, 1'b1, cyc, ret, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL ovf_timeout got %0b want 0", to); end
    rd(3'd0, v);
    vectors++; if (v !== 16'd0) begin miscompares++; $display("FAIL ovf_r0 got %0h want 0", v); end
    rd(3'd5, v);
    vectors++; if (v !== 16'd1) begin miscompares++; $display("FAIL ovf_r5 got %0h want 1", v); end
    rd(3'd6, v);
    vectors++; if (v !== 16'd0) begin miscompares++; $display("FAIL busy_write_r6 got %0h want 0", v); end
    // 16 instructions + implicit HALT at pc=16
    vectors++; if (ret !== 17) begin miscompares++; $display("FAIL ovf_retires got %0d want 17", ret); end
    vectors++; if (pc !== 8'd17) begin miscompares++; $display("FAIL ovf_pc got %0h want 11", pc); end
    vectors++; if (cyc !== 53) begin miscompares++; $display("FAIL ovf_cycles got %0d want 53", cyc); end
    $display("test_busy_write_overflow cycles=%0d retires=%0d", cyc, ret);
  endtask

  task automatic test_write_then_start();
    int ret; logic [15:0] v;
    do_reset();
    for (int i = 0; i < 16; i++) prog[i] = 16'hF000;
    load_prog();
    imem_we = 1'b1; imem_addr = 8'd0; imem_wdata = enc_i(4'h7, 3'd1, 3'd0, 6'd6);
    start = 1'b1;
    @(posedge clk); #1;
    imem_we = 1'b0; start = 1'b0;
    ret = 0;
    for (int i = 0; i < 50 && !halted; i++) begin
      @(posedge clk); #1;
      if (retire) ret++;
    end
    rd(3'd1, v);
    vectors++; if (v !== 16'd6) begin miscompares++; $display("FAIL wstart_r1 got %0h want 6", v); end
    vectors++; if (ret !== 2) begin miscompares++; $display("FAIL wstart_retires got %0d want 2", ret); end
    vectors++; if (pc !== 8'd2) begin miscompares++; $display("FAIL wstart_pc got %0h want 2", pc); end
    $display("test_write_then_start retires=%0d", ret);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mem();
    test_branch_loop();
    test_illegal();
    test_reset_mid_wb();
    test_busy_write_overflow();
    test_write_then_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
